lpbk_tgen_chk: RTL and testbench

- Debug-only QDMA-side traffic generator and checker: the far end of the loopback stream path.
- Plays the QDMA role. Masters H2C AXI-S packets with a deterministic pattern, sinks C2H data and C2H CMPT streams, checks returned data, length, QID and completion count.
- Used in simulation and on-board bring-up in place of the QDMA IP. Never instantiated in the release app.

---
 rtl/lpbk_tgen_chk_if.sv | 56 +++++
 rtl/lpbk_tgen_chk.sv | 225 ++++++++++++++++++++++
 tb/tb_lpbk_tgen_chk.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lpbk_tgen_chk_if.sv
// Loopback stream bundle: H2C master, C2H data sink and C2H CMPT sink.
// master = QDMA-side traffic generator/checker, slave = loopback app.
interface lpbk_tgen_chk_if #(
    parameter int DATA_WIDTH = 256,
    parameter int CRC_WIDTH  = 32,
    parameter int QID_WIDTH  = 11
);
    logic [DATA_WIDTH-1:0] h2c_tdata;
    logic [CRC_WIDTH-1:0]  h2c_tcrc;
    logic [QID_WIDTH-1:0]  h2c_tuser_qid;
    logic [2:0]            h2c_tuser_port_id;
    logic                  h2c_tuser_err;
    logic [31:0]           h2c_tuser_mdata;
    logic [5:0]            h2c_tuser_mty;
    logic                  h2c_tuser_zero_byte;
    logic                  h2c_tvalid;
    logic                  h2c_tlast;
    logic                  h2c_tready;

    logic [DATA_WIDTH-1:0] c2h_tdata;
    logic [15:0]           c2h_ctrl_len;
    logic [QID_WIDTH-1:0]  c2h_ctrl_qid;
    logic                  c2h_ctrl_has_cmpt;
    logic [5:0]            c2h_mty;
    logic                  c2h_tvalid;
    logic                  c2h_tlast;
    logic                  c2h_tready;

    logic                  c2h_cmpt_tvalid;
    logic [QID_WIDTH-1:0]  c2h_cmpt_ctrl_qid;
    logic                  c2h_cmpt_tready;

    modport master (
        output h2c_tdata, h2c_tcrc, h2c_tuser_qid, h2c_tuser_port_id,
        output h2c_tuser_err, h2c_tuser_mdata, h2c_tuser_mty,
        output h2c_tuser_zero_byte, h2c_tvalid, h2c_tlast,
        input  h2c_tready,
        input  c2h_tdata, c2h_ctrl_len, c2h_ctrl_qid, c2h_ctrl_has_cmpt,
        input  c2h_mty, c2h_tvalid, c2h_tlast,
        output c2h_tready,
        input  c2h_cmpt_tvalid, c2h_cmpt_ctrl_qid,
        output c2h_cmpt_tready
    );

    modport slave (
        input  h2c_tdata, h2c_tcrc, h2c_tuser_qid, h2c_tuser_port_id,
        input  h2c_tuser_err, h2c_tuser_mdata, h2c_tuser_mty,
        input  h2c_tuser_zero_byte, h2c_tvalid, h2c_tlast,
        output h2c_tready,
        output c2h_tdata, c2h_ctrl_len, c2h_ctrl_qid, c2h_ctrl_has_cmpt,
        output c2h_mty, c2h_tvalid, c2h_tlast,
        input  c2h_tready,
        output c2h_cmpt_tvalid, c2h_cmpt_ctrl_qid,
        input  c2h_cmpt_tready
    );
endinterface

// File: rtl/lpbk_tgen_chk.sv
// Loopback traffic generator/checker standing in for QDMA (debug only).
// Define LPBK_TGEN_BACKPRESSURE_EN for LFSR-driven ready/valid throttling.
module lpbk_tgen_chk #(
    parameter int DATA_WIDTH     = 256,
    parameter int PKT_WORDS_LEN  = 8,
    parameter int CRC_WIDTH      = 32,
    parameter int QID_WIDTH      = 11,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [15:0]          num_pkts_i,
    input  logic [QID_WIDTH-1:0] qid_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 timeout_o,
    output logic [15:0]          err_cnt_o,
    lpbk_tgen_chk_if.master      bus
);
    localparam int              LANES     = DATA_WIDTH / 32;
    localparam logic [7:0]      LAST_BEAT = 8'(PKT_WORDS_LEN - 1);
    localparam logic [15:0]     EXP_LEN   = 16'(PKT_WORDS_LEN * DATA_WIDTH / 8);
    localparam logic [23:0]     WD_LIMIT  = 24'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t               state_q, state_d;
    logic [15:0]          num_q, num_d;
    logic [QID_WIDTH-1:0] qid_q, qid_d;
    logic [15:0]          tx_pkt_q, tx_pkt_d, rx_pkt_q, rx_pkt_d, cmpt_q, cmpt_d;
    logic [7:0]           tx_beat_q, tx_beat_d, rx_beat_q, rx_beat_d;
    logic                 vld_q, vld_d, done_q, done_d, tmo_q, tmo_d;
    logic [23:0]          wd_q, wd_d;
    logic [15:0]          err_q, err_d;
    logic [16:0]          err_sum;
    logic [2:0]           e_rx;
    logic                 e_cm, tmo_hit;
    logic                 run, accept, c2h_rdy, cmpt_rdy;
    logic                 rx_gate, cm_gate, tx_hold;
    logic                 h2c_hs, c2h_hs, cmpt_hs, all_done, wd_fire;
    logic                 tx_last, rx_last;
    logic                 unused_has_cmpt;

    // Lane L of a beat = {packet, beat, L}
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] p,
                                                      input logic [7:0] b);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        for (int l = 0; l < LANES; l++) d[l*32 +: 32] = {p, b, 8'(l)};
        return d;
    endfunction

`ifdef LPBK_TGEN_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Free-running Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= {lfsr_q[14:0],
                            lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign rx_gate = lfsr_q[0] | lfsr_q[1];
    assign cm_gate = lfsr_q[2] | lfsr_q[3];
    assign tx_hold = lfsr_q[4] & lfsr_q[5];
`else
    assign rx_gate = 1'b1;
    assign cm_gate = 1'b1;
    assign tx_hold = 1'b0;
`endif

    assign unused_has_cmpt = bus.c2h_ctrl_has_cmpt;
    assign h2c_hs   = vld_q & bus.h2c_tready;
    assign c2h_hs   = bus.c2h_tvalid & c2h_rdy;
    assign cmpt_hs  = bus.c2h_cmpt_tvalid & cmpt_rdy;
    assign all_done = (tx_pkt_q == num_q) && (rx_pkt_q == num_q) && (cmpt_q == num_q);
    assign wd_fire  = (wd_q == WD_LIMIT);
    assign tx_last  = (tx_beat_q == LAST_BEAT);
    assign rx_last  = (rx_beat_q == LAST_BEAT);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (num_pkts_i == 16'd0) ? FIN : RUN;
            RUN:     if (all_done || wd_fire) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: run status, start acceptance, sink readies
    always_comb begin
        run      = (state_q == RUN);
        busy_o   = run;
        accept   = (state_q == IDLE) && start_i;
        c2h_rdy  = run && rx_gate;
        cmpt_rdy = run && cm_gate;
    end

    // Datapath next state: TX generator, RX/CMPT checkers, watchdog, errors
    always_comb begin
        num_d     = num_q;
        qid_d     = qid_q;
        tx_pkt_d  = tx_pkt_q;
        tx_beat_d = tx_beat_q;
        vld_d     = vld_q;
        rx_pkt_d  = rx_pkt_q;
        rx_beat_d = rx_beat_q;
        cmpt_d    = cmpt_q;
        wd_d      = wd_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        e_rx      = 3'd0;
        e_cm      = 1'b0;
        tmo_hit   = run && wd_fire && !all_done;
        err_sum   = '0;
        if (accept) begin
            num_d     = num_pkts_i;
            qid_d     = qid_i;
            tx_pkt_d  = '0;
            tx_beat_d = '0;
            vld_d     = 1'b0;
            rx_pkt_d  = '0;
            rx_beat_d = '0;
            cmpt_d    = '0;
            wd_d      = '0;
            done_d    = 1'b0;
            tmo_d     = 1'b0;
            err_d     = '0;
        end else begin
            if (h2c_hs) begin
                tx_beat_d = tx_last ? 8'd0 : tx_beat_q + 8'd1;
                tx_pkt_d  = tx_last ? tx_pkt_q + 16'd1 : tx_pkt_q;
            end
            // An offered beat is held until accepted; a new one may be withheld
            if (run && (!vld_q || h2c_hs))
                vld_d = (tx_pkt_d < num_q) && !tx_hold;
            if (!run) vld_d = 1'b0;
            if (c2h_hs) begin
                if (rx_pkt_q >= num_q) begin
                    e_rx = 3'd1;
                end else begin
                    e_rx = 3'(bus.c2h_tdata != pattern(rx_pkt_q, rx_beat_q))
                         + 3'(rx_beat_q == 8'd0 && bus.c2h_ctrl_len != EXP_LEN)
                         + 3'(rx_beat_q == 8'd0 && bus.c2h_ctrl_qid != qid_q)
                         + 3'(bus.c2h_mty != 6'd0)
                         + 3'(bus.c2h_tlast != rx_last);
                    if (bus.c2h_tlast || rx_last) begin
                        rx_pkt_d  = rx_pkt_q + 16'd1;
                        rx_beat_d = 8'd0;
                    end else begin
                        rx_beat_d = rx_beat_q + 8'd1;
                    end
                end
            end
            if (cmpt_hs) begin
                cmpt_d = cmpt_q + 16'd1;
                e_cm   = (bus.c2h_cmpt_ctrl_qid != qid_q);
            end
            if (!run || h2c_hs || c2h_hs || cmpt_hs) wd_d = '0;
            else                                     wd_d = wd_q + 24'd1;
            if (state_q == FIN) done_d = 1'b1;
            if (tmo_hit) tmo_d = 1'b1;
            err_sum = {1'b0, err_q} + 17'(e_rx) + 17'(e_cm) + 17'(tmo_hit);
            err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q     <= '0;
            qid_q     <= '0;
            tx_pkt_q  <= '0;
            tx_beat_q <= '0;
            vld_q     <= 1'b0;
            rx_pkt_q  <= '0;
            rx_beat_q <= '0;
            cmpt_q    <= '0;
            wd_q      <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            num_q     <= num_d;
            qid_q     <= qid_d;
            tx_pkt_q  <= tx_pkt_d;
            tx_beat_q <= tx_beat_d;
            vld_q     <= vld_d;
            rx_pkt_q  <= rx_pkt_d;
            rx_beat_q <= rx_beat_d;
            cmpt_q    <= cmpt_d;
            wd_q      <= wd_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign done_o    = done_q;
    assign timeout_o = tmo_q;
    assign err_cnt_o = err_q;

    assign bus.h2c_tvalid          = vld_q;
    assign bus.h2c_tdata           = vld_q ? pattern(tx_pkt_q, tx_beat_q) : '0;
    assign bus.h2c_tlast           = vld_q & tx_last;
    assign bus.h2c_tcrc            = {CRC_WIDTH{1'b0}};
    assign bus.h2c_tuser_qid       = qid_q;
    assign bus.h2c_tuser_port_id   = 3'd0;
    assign bus.h2c_tuser_err       = 1'b0;
    assign bus.h2c_tuser_mdata     = {16'd0, tx_pkt_q};
    assign bus.h2c_tuser_mty       = 6'd0;
    assign bus.h2c_tuser_zero_byte = 1'b0;
    assign bus.c2h_tready          = c2h_rdy;
    assign bus.c2h_cmpt_tready     = cmpt_rdy;
endmodule

// File: tb/tb_lpbk_tgen_chk.sv
// Testbench for lpbk_tgen_chk: loopback harness with fault injection.
// Expected error counts come from per-packet/per-beat fault tables.
module tb_lpbk_tgen_chk;
    localparam int DW = 256;
    localparam int PW = 8;
    localparam int QW = 11;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [15:0]   num;
    logic [QW-1:0] qid_in;
    logic          busy, done, tmo;
    logic [15:0]   err;

    int n_chk = 0;
    int n_fail = 0;

    lpbk_tgen_chk_if #(.DATA_WIDTH(DW), .CRC_WIDTH(32), .QID_WIDTH(QW)) ifc ();

    lpbk_tgen_chk #(
        .DATA_WIDTH(DW), .PKT_WORDS_LEN(PW), .CRC_WIDTH(32),
        .QID_WIDTH(QW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .num_pkts_i(num),
        .qid_i(qid_in), .busy_o(busy), .done_o(done), .timeout_o(tmo),
        .err_cnt_o(err), .bus(ifc)
    );

    always #5 clk = ~clk;

    // fault tables, indexed by packet (and beat) of the H2C beat being looped
    logic [DW-1:0] flip [64];
    bit            mty_bad [64];
    bit            len_bad [8];
    bit            qid_bad [8];
    bit            cmpt_bad [8];
    bit            no_cmpt, early_en;
    int            early_pkt, early_beat;
    logic [QW-1:0] run_qid;
    int            pk, bt, ix;

    assign pk = int'(ifc.h2c_tdata[31:16]) & 7;
    assign bt = int'(ifc.h2c_tdata[15:8]) & 7;
    assign ix = pk * 8 + bt;

    assign ifc.c2h_tvalid = ifc.h2c_tvalid;
    assign ifc.h2c_tready = ifc.c2h_tready;
    assign ifc.c2h_tdata  = ifc.h2c_tdata ^ (ifc.h2c_tvalid ? flip[ix] : '0);
    assign ifc.c2h_tlast  = ifc.h2c_tlast |
        (early_en && ifc.h2c_tvalid && pk == early_pkt && bt == early_beat);
    assign ifc.c2h_ctrl_len = len_bad[pk] ? 16'd200 : 16'(PW * DW / 8);
    assign ifc.c2h_ctrl_qid = qid_bad[pk] ? (run_qid ^ 11'd1) : run_qid;
    assign ifc.c2h_mty      = (ifc.h2c_tvalid && mty_bad[ix]) ? 6'd1 : 6'd0;
    assign ifc.c2h_ctrl_has_cmpt = 1'b1;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input int p, input int b);
        logic [DW-1:0] d;
        for (int l = 0; l < DW / 32; l++)
            d[l*32 +: 32] = 32'(p * 65536 + b * 256 + l);
        return d;
    endfunction

    // monitor: reference TX stream checks and CMPT generation
    int          mon_pkt, mon_beat, h2c_beats;
    bit          saw_valid, cm_pend;
    logic [31:0] lane1_cap;
    int          cq[$];

    always begin
        @(negedge clk);
        if (!rst) begin
            if (ifc.h2c_tvalid) saw_valid = 1'b1;
            if (ifc.h2c_tvalid && ifc.h2c_tready) begin
                chk("h2c_data", ifc.h2c_tdata, exp_beat(mon_pkt, mon_beat));
                chk("h2c_user",
                    DW'({ifc.h2c_tlast, ifc.h2c_tuser_qid, ifc.h2c_tuser_mdata}),
                    DW'({mon_beat == PW - 1, run_qid, 32'(mon_pkt)}));
                if (mon_pkt == 2 && mon_beat == 3)
                    lane1_cap = ifc.h2c_tdata[63:32];
                if (ifc.h2c_tlast && !no_cmpt) cq.push_back(mon_pkt);
                h2c_beats++;
                if (mon_beat == PW - 1) begin
                    mon_beat = 0;
                    mon_pkt++;
                end else begin
                    mon_beat++;
                end
            end
            if (ifc.c2h_cmpt_tvalid && ifc.c2h_cmpt_tready) cm_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            cq.delete();
            cm_pend = 1'b0;
            ifc.c2h_cmpt_tvalid = 1'b0;
        end else if (!cm_pend && cq.size() > 0) begin
            int p;
            p = cq.pop_front();
            ifc.c2h_cmpt_tvalid = 1'b1;
            ifc.c2h_cmpt_ctrl_qid = cmpt_bad[p & 7] ? (run_qid ^ 11'd2) : run_qid;
            cm_pend = 1'b1;
        end else if (!cm_pend) begin
            ifc.c2h_cmpt_tvalid = 1'b0;
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < 64; i++) begin
            flip[i] = '0;
            mty_bad[i] = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            len_bad[i] = 1'b0;
            qid_bad[i] = 1'b0;
            cmpt_bad[i] = 1'b0;
        end
        no_cmpt = 1'b0;
        early_en = 1'b0;
    endtask

    task automatic pulse_start(input int n, input logic [QW-1:0] q);
        @(posedge clk);
        #1;
        mon_pkt = 0;
        mon_beat = 0;
        h2c_beats = 0;
        saw_valid = 1'b0;
        run_qid = q;
        num = 16'(n);
        qid_in = q;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_run(input string tag, input int n, input logic [QW-1:0] q,
                          input int exp_err, input bit exp_tmo, input int exp_beats);
        bit got;
        got = 1'b0;
        pulse_start(n, q);
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk({tag, "_done"}, DW'(got), DW'(1));
        chk({tag, "_err"}, DW'(err), DW'(exp_err));
        chk({tag, "_tmo"}, DW'(tmo), DW'(exp_tmo));
        chk({tag, "_beats"}, DW'(h2c_beats), DW'(exp_beats));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
    endtask

    function automatic logic [DW-1:0] out_vec();
        return DW'({busy, done, tmo, err, ifc.h2c_tvalid, ifc.h2c_tlast,
                    ifc.h2c_tuser_mdata, ifc.h2c_tuser_qid, ifc.c2h_tready,
                    ifc.c2h_cmpt_tready, |ifc.h2c_tdata, ifc.h2c_tcrc});
    endfunction

    initial begin
        int n, e;
        bit found;
        rst = 1'b1;
        start = 1'b0;
        num = '0;
        qid_in = '0;
        run_qid = '0;
        ifc.c2h_cmpt_tvalid = 1'b0;
        ifc.c2h_cmpt_ctrl_qid = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_run("ideal", 4, 11'd5, 0, 1'b0, 32);
        chk("lane1_p2_b3", DW'(lane1_cap), DW'(32'h0002_0301));

        clear_faults();
        flip[5] = DW'(1);
        do_run("corrupt", 2, 11'd5, 1, 1'b0, 16);

        clear_faults();
        for (int p = 0; p < 3; p++) begin
            len_bad[p] = 1'b1;
            qid_bad[p] = 1'b1;
        end
        do_run("len_qid", 3, 11'd7, 6, 1'b0, 24);

        clear_faults();
        early_en = 1'b1;
        early_pkt = 1;
        early_beat = 5;
        do_run("early_tlast", 2, 11'd3, 1 + (PW - 1 - 5), 1'b0, 16);

        clear_faults();
        no_cmpt = 1'b1;
        do_run("no_cmpt", 1, 11'd4, 1, 1'b1, 8);

        clear_faults();
        pulse_start(0, 11'd1);
        @(negedge clk);
        chk("zero_done_c1", DW'({done, busy}), DW'(2'b00));
        @(negedge clk);
        chk("zero_done_c2", DW'({done, busy}), DW'(2'b10));
        repeat (5) @(negedge clk);
        chk("zero_no_valid", DW'(saw_valid), DW'(0));

        for (int it = 0; it < 8; it++) begin
            clear_faults();
            n = $urandom_range(1, 6);
            e = 0;
            for (int p = 0; p < n; p++) begin
                len_bad[p] = ($urandom_range(0, 3) == 0);
                qid_bad[p] = ($urandom_range(0, 3) == 0);
                cmpt_bad[p] = ($urandom_range(0, 3) == 0);
                e += int'(len_bad[p]) + int'(qid_bad[p]) + int'(cmpt_bad[p]);
                for (int b = 0; b < PW; b++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        flip[p * 8 + b][$urandom_range(0, DW - 1)] = 1'b1;
                        e++;
                    end
                    if ($urandom_range(0, 15) == 0) begin
                        mty_bad[p * 8 + b] = 1'b1;
                        e++;
                    end
                end
            end
            do_run("random", n, 11'($urandom), e, 1'b0, n * PW);
        end

        clear_faults();
        found = 1'b0;
        pulse_start(4, 11'd9);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (ifc.h2c_tvalid && ifc.h2c_tuser_mdata == 32'd1) found = 1'b1;
        end
        chk("rst_reach_pkt1", DW'(found), DW'(1));
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_midrun", out_vec(), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_run("after_rst", 2, 11'd6, 0, 1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
